// File: rtl/segway_pkg.sv
// Shared segway definitions: rider-detect state encoding, load-class codes and the
// default rider weight thresholds reused by the auth and steering blocks.
package segway_pkg;

   localparam logic [12:0] MIN_RIDER_WT_DEF = 13'h0200;
   localparam logic [12:0] WT_HYST_DEF      = 13'h0040;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_ON_PEND  = 2'd1,
      ST_ON       = 2'd2,
      ST_OFF_PEND = 2'd3
   } rider_state_e;

   typedef enum logic [1:0] {
      CLS_LIGHT = 2'd0,
      CLS_BAND  = 2'd1,
      CLS_HEAVY = 2'd2
   } ld_class_e;

   // Counter width able to hold the value n itself (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/deb_cnt.sv
// Saturating debounce counter; term is high when one more inc reaches the terminal count TERM.
module deb_cnt
   import segway_pkg::*;
#(
   parameter int unsigned TERM = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic term
);

   localparam int unsigned   CNT_W  = cnt_width(TERM);
   localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TERM - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != TERM_C)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign term = (cnt >= LAST_C);

endmodule

// File: rtl/rider_detect.sv
// Rider presence detector: sums the two load cells, classifies against a hysteresis band
// and debounces the decision. Define RIDER_DET_FAST_SIM_EN to shorten the debounce to 2 samples.
module rider_detect
   import segway_pkg::*;
#(
   parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
   parameter logic [12:0] WT_HYST      = WT_HYST_DEF,
   parameter int unsigned DEB_SAMPLES  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        rider_off,
   output logic [12:0] ld_sum
);

`ifdef RIDER_DET_FAST_SIM_EN
   localparam int unsigned DEB_EFF = 2;
`else
   localparam int unsigned DEB_EFF = (DEB_SAMPLES < 1) ? 1 : DEB_SAMPLES;
`endif

   // Compare at 14 bits so MIN+HYST cannot wrap and MIN-HYST never goes negative.
   function automatic ld_class_e classify(input logic [12:0] s);
      logic [13:0] s_w;
      logic [13:0] hi_thr;
      s_w    = {1'b0, s};
      hi_thr = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
      if (s_w >= hi_thr) begin
         return CLS_HEAVY;
      end
      if ((s_w + {1'b0, WT_HYST}) < {1'b0, MIN_RIDER_WT}) begin
         return CLS_LIGHT;
      end
      return CLS_BAND;
   endfunction

   logic [12:0]  sum_p0;
   ld_class_e    cls_p0;
   rider_state_e state;
   rider_state_e state_nxt;
   logic         cnt_inc;
   logic         cnt_clr;
   logic         cnt_term;

   assign sum_p0 = {1'b0, lft_ld} + {1'b0, rght_ld};
   assign cls_p0 = classify(sum_p0);

   deb_cnt #(
      .TERM (DEB_EFF)
   ) u_deb_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .term  (cnt_term)
   );

   // A sample that would complete the run jumps straight to the settled state, which
   // also makes a one-sample debounce switch on the first qualifying sample.
   always_comb begin
      state_nxt = state;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      if (vld) begin
         case (state)
            ST_OFF: begin
               if (cls_p0 == CLS_HEAVY) begin
                  if (cnt_term) begin
                     state_nxt = ST_ON;
                     cnt_clr   = 1'b1;
                  end else begin
                     state_nxt = ST_ON_PEND;
                     cnt_inc   = 1'b1;
                  end
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            ST_ON_PEND: begin
               if (cls_p0 == CLS_HEAVY) begin
                  if (cnt_term) begin
                     state_nxt = ST_ON;
                     cnt_clr   = 1'b1;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  state_nxt = ST_OFF;
                  cnt_clr   = 1'b1;
               end
            end
            ST_ON: begin
               if (cls_p0 == CLS_LIGHT) begin
                  if (cnt_term) begin
                     state_nxt = ST_OFF;
                     cnt_clr   = 1'b1;
                  end else begin
                     state_nxt = ST_OFF_PEND;
                     cnt_inc   = 1'b1;
                  end
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            ST_OFF_PEND: begin
               if (cls_p0 == CLS_LIGHT) begin
                  if (cnt_term) begin
                     state_nxt = ST_OFF;
                     cnt_clr   = 1'b1;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  state_nxt = ST_ON;
                  cnt_clr   = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_OFF;
               cnt_clr   = 1'b1;
            end
         endcase
      end
   end

   // Stage p0 -> registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         rider_off <= 1'b1;
         ld_sum    <= '0;
      end else begin
         state     <= state_nxt;
         rider_off <= !((state_nxt == ST_ON) || (state_nxt == ST_OFF_PEND));
         if (vld) begin
            ld_sum <= sum_p0;
         end
      end
   end

endmodule

// File: tb/tb_rider_detect.sv
// Directed bench for rider_detect: reset, debounced on/off, restarts, overflow,
// threshold edges, vld gaps and asynchronous reset in the middle of a debounce.
module tb_rider_detect;

`ifdef RIDER_DET_FAST_SIM_EN
   localparam int D = 2;
`else
   localparam int D = 16;
`endif
   localparam int BN = (D > 10) ? 10 : D - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        rider_off;
   logic [12:0] ld_sum;

   int n_vec = 0;
   int n_err = 0;

   rider_detect dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld       (vld),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .rider_off (rider_off),
      .ld_sum    (ld_sum)
   );

   always #5 clk = ~clk;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_sum(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic smp(input logic [11:0] l, input logic [11:0] r);
      @(negedge clk);
      vld     = 1'b1;
      lft_ld  = l;
      rght_ld = r;
      @(posedge clk);
      #1;
      vld = 1'b0;
   endtask

   task automatic idle_chk(input int n, input logic exp_off, input logic [12:0] exp_sum);
      repeat (n) begin
         @(negedge clk);
         lft_ld  = 12'($urandom);
         rght_ld = 12'($urandom);
         @(posedge clk);
         #1;
         chk_bit("gap_hold_off", rider_off, exp_off);
         chk_sum("gap_hold_sum", ld_sum, exp_sum);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      vld     = 1'b0;
      lft_ld  = '0;
      rght_ld = '0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vld     = 1'($urandom);
         lft_ld  = 12'($urandom);
         rght_ld = 12'($urandom);
         @(posedge clk);
         #1;
         chk_bit("rst_off", rider_off, 1'b1);
         chk_sum("rst_sum", ld_sum, 13'h0000);
      end
      @(negedge clk);
      vld   = 1'b0;
      rst_n = 1'b1;

      // rider on: 0x300 is HEAVY, falls on the D-th edge
      for (int i = 1; i <= D; i++) begin
         smp(12'h180, 12'h180);
         chk_bit("on_run", rider_off, (i == D) ? 1'b0 : 1'b1);
      end
      chk_sum("on_sum", ld_sum, 13'h0300);

      smp(12'h0F8, 12'h0F8);
      chk_bit("on_band_hold", rider_off, 1'b0);
      chk_sum("band_sum", ld_sum, 13'h01F0);

      // rider off with a 0x200 BAND sample restarting the count
      for (int i = 1; i <= D - 1; i++) begin
         smp(12'h080, 12'h080);
         chk_bit("offp_run", rider_off, 1'b0);
      end
      smp(12'h100, 12'h100);
      chk_bit("off_restart", rider_off, 1'b0);
      chk_sum("restart_sum", ld_sum, 13'h0200);
      for (int i = 1; i <= D; i++) begin
         smp(12'h080, 12'h080);
         chk_bit("off_run", rider_off, (i == D) ? 1'b1 : 1'b0);
      end
      chk_sum("off_sum", ld_sum, 13'h0100);

      // bounce on
      for (int i = 0; i < BN; i++) begin
         smp(12'h180, 12'h180);
         chk_bit("bounce_a", rider_off, 1'b1);
      end
      smp(12'h0F8, 12'h0F8);
      chk_bit("bounce_band", rider_off, 1'b1);
      for (int i = 1; i <= D - 1; i++) begin
         smp(12'h180, 12'h180);
         chk_bit("bounce_b", rider_off, 1'b1);
      end
      smp(12'h180, 12'h180);
      chk_bit("bounce_on", rider_off, 1'b0);

      for (int i = 1; i <= D; i++) begin
         smp(12'h080, 12'h080);
      end
      chk_bit("leave_on", rider_off, 1'b1);

      // full-scale inputs: 13-bit sum without wrap, classified HEAVY
      for (int i = 1; i <= D; i++) begin
         smp(12'hFFF, 12'hFFF);
         chk_sum("ovf_sum", ld_sum, 13'h1FFE);
         chk_bit("ovf_run", rider_off, (i == D) ? 1'b0 : 1'b1);
      end

      // lower threshold edge: 0x1BF is LIGHT, 0x1C0 is BAND
      smp(12'h0DF, 12'h0E0);
      chk_bit("lo_edge_light", rider_off, 1'b0);
      smp(12'h0E0, 12'h0E0);
      chk_bit("lo_edge_band", rider_off, 1'b0);
      for (int i = 1; i <= D - 1; i++) begin
         smp(12'h0DF, 12'h0E0);
         chk_bit("lo_edge_restart", rider_off, 1'b0);
      end
      smp(12'h0DF, 12'h0E0);
      chk_bit("lo_edge_off", rider_off, 1'b1);

      // HEAVY samples separated by 1..50 idle cycles with noisy inputs
      for (int i = 1; i <= D; i++) begin
         smp(12'h180, 12'h180);
         chk_bit("gap_run", rider_off, (i == D) ? 1'b0 : 1'b1);
         if (i < D) begin
            idle_chk(int'($urandom_range(50, 1)), 1'b1, 13'h0300);
         end
      end
      idle_chk(3, 1'b0, 13'h0300);

      // asynchronous reset in the middle of OFF_PEND
      smp(12'h080, 12'h080);
      chk_bit("pend_before_rst", rider_off, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_bit("async_rst_off", rider_off, 1'b1);
      chk_sum("async_rst_sum", ld_sum, 13'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // upper threshold edge: 0x240 is HEAVY, run restarts from zero after reset
      for (int i = 1; i <= D; i++) begin
         smp(12'h120, 12'h120);
         chk_bit("hi_edge_run", rider_off, (i == D) ? 1'b0 : 1'b1);
      end
      chk_sum("hi_edge_sum", ld_sum, 13'h0240);
      smp(12'h11F, 12'h120);
      chk_bit("hi_edge_band_hold", rider_off, 1'b0);
      chk_sum("hi_edge_band_sum", ld_sum, 13'h023F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rider_detect.md
RIDER_DETECT -- requirements
Module: rider_detect

Interface
REQ-001 The block SHALL have parameter MIN_RIDER_WT, default 13'h0200, meaning nominal rider-present threshold on the summed load.
REQ-002 The block SHALL have parameter WT_HYST, default 13'h0040, meaning half-width of the hysteresis band around MIN_RIDER_WT.
REQ-003 The block SHALL have parameter DEB_SAMPLES, default 16, meaning consecutive qualifying samples required to change the rider decision.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port vld, input, 1 bit: single-cycle strobe marking a new load-cell sample pair.
REQ-007 The block SHALL have port lft_ld, input, 12 bits: left load cell reading, unsigned.
REQ-008 The block SHALL have port rght_ld, input, 12 bits: right load cell reading, unsigned.
REQ-009 The block SHALL have port rider_off, output, 1 bit: registered; high = no qualified rider, consumed by the authentication FSM.
REQ-010 The block SHALL have port ld_sum, output, 13 bits: registered sum of the last valid sample pair.

Function
REQ-011 On each vld, the block SHALL register ld_sum = lft_ld + rght_ld at 13-bit width with no overflow or saturation; the update is visible 1 cycle after vld.
REQ-012 Classification SHALL use the sum of the current strobed inputs, not the stale ld_sum.
- HEAVY when sum >= MIN_RIDER_WT + WT_HYST.
- LIGHT when sum < MIN_RIDER_WT - WT_HYST.
- otherwise BAND.
REQ-013 The FSM SHALL have states OFF, ON_PEND, ON and OFF_PEND, with a debounce counter sized for DEB_SAMPLES.
REQ-014 In OFF, a HEAVY sample SHALL move to ON_PEND with count = 1; LIGHT and BAND samples SHALL hold OFF.
REQ-015 In ON_PEND:
- each HEAVY sample SHALL increment the count;
- reaching DEB_SAMPLES SHALL move to ON;
- any LIGHT or BAND sample SHALL return to OFF and clear the count.
REQ-016 In ON, a LIGHT sample SHALL move to OFF_PEND with count = 1; HEAVY and BAND samples SHALL hold ON.
REQ-017 In OFF_PEND:
- each LIGHT sample SHALL increment the count;
- reaching DEB_SAMPLES SHALL move to OFF;
- any HEAVY or BAND sample SHALL return to ON and clear the count.
REQ-018 State and count SHALL change only on cycles with vld high; cycles without vld SHALL hold everything.
REQ-019 rider_off SHALL be 0 exactly when the state is ON or OFF_PEND, registered and updated on the same edge as the state.
REQ-020 The transition to ON SHALL occur on the edge of the DEB_SAMPLES-th consecutive HEAVY vld.
REQ-021 The transition to OFF SHALL occur on the edge of the DEB_SAMPLES-th consecutive LIGHT vld.
REQ-022 The debounce counter SHALL saturate and never wrap.
REQ-023 DEB_SAMPLES = 1 SHALL produce a transition on the first qualifying sample.
REQ-024 Back-to-back vld on every cycle SHALL be supported with no dropped samples.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state OFF, count 0, rider_off 1 and ld_sum 0, including mid-debounce; operation SHALL resume on the first clk edge after deassertion.

Configuration
REQ-026 With macro RIDER_DET_FAST_SIM_EN defined, the effective debounce length SHALL be 2 samples regardless of DEB_SAMPLES, for short simulations.
REQ-027 Without RIDER_DET_FAST_SIM_EN, the effective debounce length SHALL be DEB_SAMPLES.

Structure
REQ-028 The state enum and the default MIN_RIDER_WT and WT_HYST constants SHALL live in the shared package segway_pkg, for reuse by the auth and steering blocks.
REQ-029 The debounce counter SHALL be a sub-module, deb_cnt, with inc, clr and a terminal flag; all other logic SHALL be local to the block.

Verification
REQ-030 Reset check: hold rst_n low with random inputs -> rider_off = 1 and ld_sum = 0 throughout.
REQ-031 Rider on: 16 vld pulses with lft = rght = 12'h180 (sum 0x300) -> rider_off falls on the 16th vld edge, not earlier; ld_sum = 0x300.
REQ-032 Bounce on: 10 HEAVY samples, one sample at sum 0x1F0 (BAND), then 15 HEAVY -> rider_off stays 1; a 16th HEAVY sample -> rider_off = 0.
REQ-033 Rider off: from ON, 16 samples at sum 0x100 -> rider_off rises on the 16th edge; any 0x200 sample inside the run restarts the count.
REQ-034 Overflow: lft = rght = 12'hFFF -> ld_sum = 13'h1FFE and the sample is classified HEAVY.
REQ-035 Mid-operation events: assert rst_n mid OFF_PEND -> immediate OFF; vld gaps of 1–50 idle cycles between HEAVY samples -> same 16-sample latency; with RIDER_DET_FAST_SIM_EN -> transition after 2 samples.
